// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Purpose  : Shared types and constants for the vector lane sequencer.
//            Holds the sequencer state encoding, the vector ALUControl codes
//            and the scalar ALUControl codes they map onto.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    // Vector ALUControl codes presented by decode
    localparam logic [3:0] c_VADD = 4'b1000;
    localparam logic [3:0] c_VSUB = 4'b1001;
    localparam logic [3:0] c_VAND = 4'b1010;
    localparam logic [3:0] c_VORR = 4'b1011;
    localparam logic [3:0] c_VXOR = 4'b1111;

    // Scalar ALUControl codes applied to the shared ALU
    localparam logic [3:0] c_ADD  = 4'b0000;
    localparam logic [3:0] c_SUB  = 4'b0001;
    localparam logic [3:0] c_AND  = 4'b0010;
    localparam logic [3:0] c_ORR  = 4'b0011;
    localparam logic [3:0] c_XOR  = 4'b0111;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_op_map.sv
`default_nettype none
// ============================================================================
// Module   : vec_op_map
// Purpose  : Combinational map from a vector ALUControl code to the scalar
//            code the ALU executes per lane, plus a legality flag.
// Ports    : alu_ctrl (in, 4)  - ALUControl from decode
//            legal    (out, 1) - alu_ctrl is one of the vector codes
//            op       (out, 4) - mapped scalar code (0000 when illegal)
// Revision : 1.0 - initial release
// ============================================================================
module vec_op_map
    import vec_pkg::*;
(
    input  logic [3:0] alu_ctrl,
    output logic       legal,
    output logic [3:0] op
);

    always_comb begin
        legal = 1'b1;
        op    = c_ADD;
        case (alu_ctrl)
            c_VADD:  op = c_ADD;
            c_VSUB:  op = c_SUB;
            c_VAND:  op = c_AND;
            c_VORR:  op = c_ORR;
            c_VXOR:  op = c_XOR;
            default: begin
                legal = 1'b0;
                op    = 4'b0000;
            end
        endcase
    end

endmodule : vec_op_map
`default_nettype wire

// File: rtl/vec_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vec_lane_sequencer
// Purpose  : Executes a vector ALU instruction by stepping the scalar ALU
//            across LANES lanes, assembling the per-lane results into one
//            packed word and issuing a single register-file write.
// Ports    : clk         (in)          rising-edge clock
//            reset       (in)          asynchronous active-low reset
//            start       (in)          current instruction is a vector op
//            alu_ctrl    (in, 4)       ALUControl from decode
//            lane_result (in, LANE_W)  ALU result for the selected lane
//            stall       (out)         hold PC / instruction register
//            lane_sel    (out)         lane index to operand slice muxes
//            lane_op     (out, 4)      scalar ALU code during RUN
//            vec_we      (out)         register-file write enable (WB)
//            vec_result  (out, 32)     packed result, lane i at [i*LANE_W +:]
//            busy        (out)         sequencer not idle
//            illegal     (out)         start with a non-vector code
// Revision : 1.0 - initial release
// ============================================================================
module vec_lane_sequencer
    import vec_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int LANE_W = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [3:0]                  alu_ctrl,
    input  logic [LANE_W-1:0]           lane_result,
    output logic                        stall,
    output logic [$clog2(LANES)-1:0]    lane_sel,
    output logic [3:0]                  lane_op,
    output logic                        vec_we,
    output logic [LANES*LANE_W-1:0]     vec_result,
    output logic                        busy,
    output logic                        illegal
);

    localparam int                 c_SEL_W = $clog2(LANES);
    localparam logic [c_SEL_W-1:0] c_LAST  = c_SEL_W'(LANES - 1);

    state_t               r_state;
    logic [c_SEL_W-1:0]   r_cnt;
    logic [3:0]           r_op;
    logic [LANE_W-1:0]    r_lane [LANES];

    logic                 w_legal;
    logic [3:0]           w_op;
    logic                 w_accept;
    logic [LANES-1:0]     w_lane_we;

    vec_op_map u_op_map (
        .alu_ctrl (alu_ctrl),
        .legal    (w_legal),
        .op       (w_op)
    );

    assign w_accept = (r_state == S_IDLE) && start && w_legal;

    // Sequencer FSM, lane counter and op latch. The counter naturally wraps
    // to 0 on the last lane, leaving it ready for the next accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op    <= w_op;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_cnt <= r_cnt + c_SEL_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Result buffer: one register per lane with its own write enable. The
    // whole buffer is cleared on accept so no lane of a previous op leaks.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lane_we[gi] = (r_state == S_RUN) && (r_cnt == c_SEL_W'(gi));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_lane[gi] <= '0;
                end else if (w_accept) begin
                    r_lane[gi] <= '0;
                end else if (w_lane_we[gi]) begin
                    r_lane[gi] <= lane_result;
                end
            end

            assign vec_result[gi*LANE_W +: LANE_W] = r_lane[gi];
        end
    endgenerate

    // The combinational outputs are qualified by reset so that every output
    // reads 0 while reset is held, regardless of start/alu_ctrl.
    assign stall    = reset && (w_accept || (r_state == S_RUN));
    assign illegal  = reset && (r_state == S_IDLE) && start && !w_legal;
    assign lane_sel = r_cnt;
    assign lane_op  = (r_state == S_RUN) ? r_op : 4'b0000;
    assign vec_we   = (r_state == S_WB);
    assign busy     = (r_state != S_IDLE);

endmodule : vec_lane_sequencer
`default_nettype wire

// File: tb/tb_vec_lane_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_lane_sequencer
// Purpose  : Directed self-checking bench for vec_lane_sequencer (LANES=4,
//            LANE_W=8). Inputs change 1 time unit after the rising edge and
//            outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_lane_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  alu_ctrl;
    logic [7:0]  lane_result;
    logic        stall;
    logic [1:0]  lane_sel;
    logic [3:0]  lane_op;
    logic        vec_we;
    logic [31:0] vec_result;
    logic        busy;
    logic        illegal;

    int n_checks = 0;
    int n_errors = 0;

    int cyc_cnt = 0;
    int we_total = 0;
    int we_times[$];

    vec_lane_sequencer #(.LANES(4), .LANE_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_ctrl    (alu_ctrl),
        .lane_result (lane_result),
        .stall       (stall),
        .lane_sel    (lane_sel),
        .lane_op     (lane_op),
        .vec_we      (vec_we),
        .vec_result  (vec_result),
        .busy        (busy),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records the falling-edge cycle index of every write pulse.
    always @(negedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (vec_we) begin
            we_total <= we_total + 1;
            we_times.push_back(cyc_cnt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    // Packs every output for an all-zero check.
    function automatic logic [31:0] outs_or();
        return {31'd0, (stall | vec_we | busy | illegal | (|lane_sel) | (|lane_op) | (|vec_result))};
    endfunction

    logic [7:0] vals [4];
    int stall_cnt;
    int we_before;

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        alu_ctrl    = 4'b0000;
        lane_result = 8'h00;
        #2;
        check("reset_outputs", outs_or(), 32'd0);
        step(); step();
        reset = 1'b1;
        step();

        // ---------------- idle with arbitrary alu_ctrl ----------------
        for (int k = 0; k < 4; k++) begin
            alu_ctrl = 4'(k * 5 + 3);
            sample();
            check("idle_outputs", outs_or(), 32'd0);
            step();
        end

        // ---------------- VADD ----------------
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        stall_cnt = 0;
        start = 1'b1; alu_ctrl = 4'b1000;
        sample();
        check("vadd_accept_stall", {31'd0, stall}, 32'd1);
        check("vadd_accept_busy", {31'd0, busy}, 32'd0);
        if (stall) stall_cnt++;
        step();
        start = 1'b0; alu_ctrl = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            lane_result = vals[i];
            sample();
            check("vadd_lane_sel", {30'd0, lane_sel}, 32'(i));
            check("vadd_lane_op", {28'd0, lane_op}, 32'h0);
            check("vadd_run_busy", {31'd0, busy}, 32'd1);
            check("vadd_run_we", {31'd0, vec_we}, 32'd0);
            if (stall) stall_cnt++;
            step();
        end
        sample();
        check("vadd_wb_we", {31'd0, vec_we}, 32'd1);
        check("vadd_wb_stall", {31'd0, stall}, 32'd0);
        check("vadd_result", vec_result, 32'h44332211);
        if (stall) stall_cnt++;
        step();
        sample();
        check("vadd_after_we", {31'd0, vec_we}, 32'd0);
        check("vadd_after_busy", {31'd0, busy}, 32'd0);
        check("vadd_stall_cycles", 32'(stall_cnt), 32'd5);
        step();

        // ---------------- VXOR, alu_ctrl toggled mid-run ----------------
        start = 1'b1; alu_ctrl = 4'b1111;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lane_result = 8'hA0 + 8'(i);
            if (i == 1) alu_ctrl = 4'b1000;
            if (i == 2) begin start = 1'b1; end
            sample();
            check("vxor_lane_op", {28'd0, lane_op}, 32'h7);
            step();
        end
        start = 1'b0;
        sample();
        check("vxor_result", vec_result, 32'hA3A2A1A0);
        check("vxor_wb_we", {31'd0, vec_we}, 32'd1);
        step();

        // ---------------- illegal code ----------------
        we_before = we_total;
        start = 1'b1; alu_ctrl = 4'b1100;
        sample();
        check("illegal_pulse", {31'd0, illegal}, 32'd1);
        check("illegal_stall", {31'd0, stall}, 32'd0);
        check("illegal_busy", {31'd0, busy}, 32'd0);
        step();
        start = 1'b0;
        sample();
        check("illegal_cleared", {31'd0, illegal}, 32'd0);
        check("illegal_busy_after", {31'd0, busy}, 32'd0);
        step(); step();
        check("illegal_no_we", 32'(we_total), 32'(we_before));

        // ---------------- reset during RUN lane 2 ----------------
        we_before = we_total;
        start = 1'b1; alu_ctrl = 4'b1010;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lane_result = 8'h5A + 8'(i);
            step();
        end
        sample();
        check("abort_lane2_sel", {30'd0, lane_sel}, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("abort_async_outputs", outs_or(), 32'd0);
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) step();
        sample();
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        check("abort_result_zero", vec_result, 32'd0);
        check("abort_no_we", 32'(we_total), 32'(we_before));
        step();

        // ---------------- two back-to-back VSUB ----------------
        we_times.delete();
        start = 1'b1; alu_ctrl = 4'b1001;
        step();
        start = 1'b0;
        vals[0] = 8'h01; vals[1] = 8'h02; vals[2] = 8'h03; vals[3] = 8'h04;
        for (int i = 0; i < 4; i++) begin
            lane_result = vals[i];
            sample();
            check("vsub1_lane_op", {28'd0, lane_op}, 32'h1);
            step();
        end
        sample();
        check("vsub1_result", vec_result, 32'h04030201);
        step();
        // Second op presented in the cycle right after WB.
        start = 1'b1; alu_ctrl = 4'b1001;
        sample();
        check("vsub2_accept_stall", {31'd0, stall}, 32'd1);
        step();
        start = 1'b0;
        vals[0] = 8'h50; vals[1] = 8'h60; vals[2] = 8'h70; vals[3] = 8'h80;
        for (int i = 0; i < 4; i++) begin
            lane_result = vals[i];
            sample();
            if (i == 0) check("vsub2_buffer_cleared", vec_result, 32'd0);
            check("vsub2_lane_sel", {30'd0, lane_sel}, 32'(i));
            step();
        end
        sample();
        check("vsub2_result", vec_result, 32'h80706050);
        step();
        sample();
        check("vsub_we_count", 32'(we_times.size()), 32'd2);
        if (we_times.size() == 2)
            check("vsub_we_spacing", 32'(we_times[1] - we_times[0]), 32'd6);
        else
            check("vsub_we_spacing", 32'hFFFF_FFFF, 32'd6);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vec_lane_sequencer
`default_nettype wire
